// File: rtl/instr_queue_if.sv
// Fetch/decode handshake bundle for instr_queue.
// DEPTH must match the queue's DEPTH so that count has the right width.
interface instr_queue_if #(
  parameter int DEPTH = 8
);
  logic                     flush;
  logic                     push;
  logic [29:0]              instr;
  logic                     queueFull;
  logic                     instrValid;
  logic [31:0]              instrOut;
  logic                     pop;
  logic [$clog2(DEPTH):0]   count;

  modport master (
    output flush, push, instr, pop,
    input  queueFull, instrValid, instrOut, count
  );

  modport slave (
    input  flush, push, instr, pop,
    output queueFull, instrValid, instrOut, count
  );
endinterface

// File: rtl/instr_queue.sv
// instr_queue: fetch-to-decode instruction FIFO with flush on redirect/interrupt.
// Defining INSTR_QUEUE_BYPASS_EN lets a push into an empty queue reach decode in the same cycle.
module instr_queue #(
  parameter int          XLEN  = 32,
  parameter int          DEPTH = 8,
  parameter logic [31:0] NOP   = 32'h00000013
) (
  input logic          clock,
  input logic          reset,
  instr_queue_if.slave q
);
  localparam int          PW   = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

  if (XLEN != 32 && XLEN != 64) begin : gBadXlen
    $error("instr_queue: XLEN must be 32 or 64");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : gBadDepth
    $error("instr_queue: DEPTH must be a power of 2 and at least 2");
  end

  logic [29:0]   mem [DEPTH];
  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;
  logic [PW:0]   cnt;
  logic          storedValid;
  logic          bypass;
  logic          pushAcc;
  logic          doWrite;
  logic          doRead;

`ifdef INSTR_QUEUE_BYPASS_EN
  assign bypass = (cnt == '0) && q.push && !q.flush;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed word that decode pops in the same cycle never touches storage.
  always_comb begin
    storedValid = (cnt != '0);
    pushAcc     = q.push && (cnt != FULL) && !q.flush;
    doWrite     = pushAcc && !(bypass && q.pop);
    doRead      = q.pop && storedValid && !q.flush;
  end

  assign q.queueFull  = (cnt == FULL);
  assign q.instrValid = storedValid || bypass;
  assign q.count      = cnt;
  assign q.instrOut   = storedValid ? {mem[rdPtr], 2'b11} :
                        bypass      ? {q.instr, 2'b11}    : NOP;

  always_ff @(posedge clock) begin
    if (reset || q.flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      cnt   <= '0;
    end else begin
      if (doWrite) wrPtr <= wrPtr + 1'b1;
      if (doRead)  rdPtr <= rdPtr + 1'b1;
      case ({doWrite, doRead})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (doWrite && !reset) mem[wrPtr] <= q.instr;
  end
endmodule

// File: tb/tb_instr_queue.sv
// Scoreboard bench for instr_queue: directed scenarios followed by randomized traffic.
module tb_instr_queue;
  localparam int          DEPTH = 8;
  localparam logic [31:0] NOP   = 32'h00000013;
`ifdef INSTR_QUEUE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  // Expected contents of the queue, oldest first.
  logic [29:0] expQ[$];

  instr_queue_if #(.DEPTH(DEPTH)) qif();

  instr_queue #(.XLEN(32), .DEPTH(DEPTH), .NOP(NOP)) dut (
    .clock(clock),
    .reset(reset),
    .q    (qif)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model is updated after the monitor has sampled.
  task automatic cycle(input bit p, input logic [29:0] w, input bit o, input bit f, input bit r);
    int sz;
    @(negedge clock);
    reset     = r;
    qif.push  = p;
    qif.instr = w;
    qif.pop   = o;
    qif.flush = f;
    sz = expQ.size();
    #2;
    if (r || f) expQ.delete();
    else if (p && sz < DEPTH && !(BYPASS && sz == 0 && o)) expQ.push_back(w);
  endtask

  task automatic idle();
    cycle(1'b0, 30'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pushW(input logic [29:0] w);
    cycle(1'b1, w, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic popW();
    cycle(1'b0, 30'h0, 1'b1, 1'b0, 1'b0);
  endtask

  // Monitor: compares visible state to the model and retires consumed entries.
  int          monN;
  bit          monByp;
  bit          monValid;
  logic [31:0] monOut;
  initial begin
    forever begin
      @(negedge clock);
      #1;
      if (reset === 1'b0) begin
        monN     = expQ.size();
        monByp   = BYPASS && monN == 0 && qif.push && !qif.flush;
        monValid = (monN != 0) || monByp;
        monOut   = (monN != 0) ? {expQ[0], 2'b11} : monByp ? {qif.instr, 2'b11} : NOP;
        chk("count", 32'(qif.count), 32'(monN));
        chk("queueFull", 32'(qif.queueFull), 32'(monN == DEPTH));
        chk("instrValid", 32'(qif.instrValid), 32'(monValid));
        chk("instrOut", qif.instrOut, monOut);
        if (qif.pop && monValid && !qif.flush && monN != 0) void'(expQ.pop_front());
      end
    end
  end

  initial begin
    int pw;
    reset     = 1'b1;
    qif.push  = 1'b0;
    qif.instr = '0;
    qif.pop   = 1'b0;
    qif.flush = 1'b0;
    repeat (2) cycle(1'b0, 30'h0, 1'b0, 1'b0, 1'b1);
    idle();
    chk("reset instrOut", qif.instrOut, 32'h00000013);
    chk("reset instrValid", 32'(qif.instrValid), 32'd0);

    // Single push then pop.
    pushW(30'h1);
    popW();
    chk("t1 instrOut", qif.instrOut, 32'h00000007);
    chk("t1 count", 32'(qif.count), 32'd1);
    idle();
    chk("t1 empty instrOut", qif.instrOut, 32'h00000013);

    // Fill, overflow attempt, drain in order.
    for (int i = 0; i < 8; i++) pushW(30'h10 + 30'(i));
    pushW(30'h18);
    chk("t2 queueFull", 32'(qif.queueFull), 32'd1);
    chk("t2 count", 32'(qif.count), 32'd8);
    for (int i = 0; i < 8; i++) popW();
    idle();
    chk("t2 drained valid", 32'(qif.instrValid), 32'd0);

    // Steady occupancy of 3 with push and pop every cycle across pointer wrap.
    for (int i = 0; i < 3; i++) pushW(30'h100 + 30'(i));
    for (int i = 0; i < 20; i++) cycle(1'b1, 30'h200 + 30'(i), 1'b1, 1'b0, 1'b0);
    idle();
    chk("t3 count", 32'(qif.count), 32'd3);
    for (int i = 0; i < 3; i++) popW();

    // Flush with simultaneous push and pop.
    for (int i = 0; i < 5; i++) pushW(30'h300 + 30'(i));
    cycle(1'b1, 30'h2aa, 1'b1, 1'b1, 1'b0);
    idle();
    chk("t4 count", 32'(qif.count), 32'd0);
    chk("t4 instrValid", 32'(qif.instrValid), 32'd0);

    // Full queue with push and pop together: only the pop takes effect.
    for (int i = 0; i < 8; i++) pushW(30'h400 + 30'(i));
    cycle(1'b1, 30'h3f, 1'b1, 1'b0, 1'b0);
    idle();
    chk("t5 count", 32'(qif.count), 32'd7);
    chk("t5 queueFull", 32'(qif.queueFull), 32'd0);
    for (int i = 0; i < 7; i++) popW();

    // Push and pop into an empty queue.
    cycle(1'b1, 30'h5, 1'b1, 1'b0, 1'b0);
    chk("t6 instrValid", 32'(qif.instrValid), BYPASS ? 32'd1 : 32'd0);
    chk("t6 instrOut", qif.instrOut, BYPASS ? 32'h00000017 : NOP);
    idle();
    chk("t6 count", 32'(qif.count), BYPASS ? 32'd0 : 32'd1);
    if (!BYPASS) popW();

    // Reset while full.
    for (int i = 0; i < 8; i++) pushW(30'h500 + 30'(i));
    cycle(1'b0, 30'h0, 1'b0, 1'b0, 1'b1);
    idle();
    chk("t7 queueFull", 32'(qif.queueFull), 32'd0);

    // Randomized traffic, alternating fill-heavy and drain-heavy phases.
    for (int i = 0; i < 3000; i++) begin
      pw = ((i / 200) % 2 != 0) ? 80 : 30;
      cycle($urandom_range(99) < pw, 30'($urandom), $urandom_range(99) < 50,
            $urandom_range(99) < 3, $urandom_range(999) < 5);
    end
    idle();
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_queue.md
Name: instr_queue

Overview:
- Instruction FIFO between the fetch stage and decode.
- Write side is the fetch stage: fetch pushes 30-bit compressed-free instruction words (bits [31:2]) and stalls on queueFull.
- Read side presents full 32-bit instructions to decode with a valid/pop handshake.
- flush empties the queue on branch redirect or interrupt.

Parameters:
- XLEN, 32: width of GPR. Must be 32 or 64. Carried for consistency; the data path is always 32 bits.
- DEPTH, 8: number of entries. Must be a power of 2 and ≥ 2.
- NOP, 32'h00000013: value driven on instrOut when the queue is empty.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous reset, active-high.
- flush  input  1  discards all entries (redirect/interrupt).
- push  input  1  fetch writes instr this cycle.
- instr  input  30  instruction bits [31:2] from fetch.
- queueFull  output  1  queue holds DEPTH entries; fetch must not push.
- instrValid  output  1  head entry valid for decode.
- instrOut  output  32  head instruction, {instr,2'b11}.
- pop  input  1  decode consumes the head this cycle.
- count  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset, sampled at the clock edge: wrPtr=0, rdPtr=0, count=0. Resulting outputs: queueFull=0, instrValid=0, instrOut=NOP. Storage array is not reset.
- Priority at each edge: reset > flush > normal operation.
- flush=1: pointers and count go to 0 in the next cycle. Any push or pop in the same cycle is discarded. The next cycle has instrValid=0.
- Push is accepted iff push=1 && !queueFull && !flush. On accept: mem[wrPtr] <= instr; wrPtr increments, wrapping modulo DEPTH.
- Pop is accepted iff pop=1 && instrValid && !flush. On accept: rdPtr increments, wrapping modulo DEPTH.
- Push while full: ignored, no state change, even if a pop occurs the same cycle. queueFull is combinational from count only.
- Pop while empty: ignored, no state change.
- count update: +1 on push only, −1 on pop only, unchanged on both or neither. It never exceeds DEPTH and never underflows.
- queueFull = (count==DEPTH). instrValid = (count!=0).
- instrOut = instrValid ? {mem[rdPtr],2'b11} : NOP. The read is combinational from the head.
- Latency: data pushed in cycle N is visible on instrOut with instrValid=1 in cycle N+1.
- Simultaneous push and pop with 0<count<DEPTH: both accepted. Head advances, new entry is written at the tail, count is unchanged.
- Pointer wrap: ptr width is $clog2(DEPTH). Entries are returned strictly in FIFO order across the wrap.
- Reset or flush while full: queueFull deasserts the next cycle. Stale data is never presented.

Optional Feature:
- Macro: INSTR_QUEUE_BYPASS_EN.
- Defined: when count==0 && push && !flush, instrValid=1 and instrOut={instr,2'b11} in the same cycle, combinationally.
  - If pop=1 that cycle, the word is consumed directly and is not stored; count stays 0.
  - If pop=0, the word is stored as normal.
- Not defined: no bypass. An empty queue always shows instrValid=0 and instrOut=NOP, and the minimum latency is 1 cycle.

Test Plan:
- Reset, then push 0x00000004 (instr=30'h1, instrOut=0x00000007) -> next cycle instrValid=1, instrOut=32'h00000007, count=1. Pop -> next cycle instrValid=0, instrOut=32'h00000013.
- Push 8 words 30'h10..30'h17 with no pop -> queueFull=1, count=8. A 9th push of 30'h18 is ignored. 8 pops return {30'h10..30'h17,2'b11} in order, then instrValid=0.
- Keep count=3 with push and pop every cycle for 20 cycles (wraps both pointers) -> count stays 3; output sequence equals input sequence delayed by 3 entries.
- Fill to count=5, assert flush with push=1 and pop=1 in the same cycle -> next cycle count=0, instrValid=0, queueFull=0; the pushed word never appears.
- Full queue (count=8), push=1 and pop=1 same cycle -> pop accepted, push rejected, count=7, queueFull=0.
- With INSTR_QUEUE_BYPASS_EN defined: empty queue, push 30'h5 and pop=1 same cycle -> instrValid=1, instrOut=32'h00000017 that cycle, count remains 0. Without the macro -> instrValid=0 that cycle, count=1 next cycle.
